// File: rtl/button_debounce_pkg.sv
// Shared project constants for the push-button / slide-switch debouncer.
package button_debounce_pkg;

  localparam int unsigned NumButtonsDefault     = 5;
  localparam int unsigned DebounceCyclesDefault = 16;
  // Stable-sample count used on the board build (10 ms at 100 MHz).
  localparam int unsigned DebounceCyclesBoard   = 1_000_000;

  // Counter width able to hold 0 .. cycles-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Raw inputs and debounced outputs of the debouncer, bundled as one port.
interface button_debounce_if
  import button_debounce_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = NumButtonsDefault
) ();

  logic [NUM_BUTTONS-1:0] buttons_raw;
  logic                   switch_raw;
  logic [NUM_BUTTONS-1:0] buttons;
  logic [NUM_BUTTONS-1:0] buttons_pulse;
  logic                   switch;

  // Board / environment side: drives raw levels, observes debounced ones.
  modport master (
    output buttons_raw,
    output switch_raw,
    input  buttons,
    input  buttons_pulse,
    input  switch
  );

  // Debouncer side.
  modport slave (
    input  buttons_raw,
    input  switch_raw,
    output buttons,
    output buttons_pulse,
    output switch
  );

endinterface

// File: rtl/button_debounce_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter, stable level
// flop and registered rise-edge pulse.
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  // Count consecutive mismatching samples; any agreement discards the count.
  always_comb begin
    sync_d   = {sync_q[0], raw_i};
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync_q[1];
        pulse_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level_o = stable_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/button_debounce.sv
// Debouncer for NUM_BUTTONS push buttons plus one slide switch. Every output
// comes straight from a flop inside a channel.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned NUM_BUTTONS     = NumButtonsDefault
) (
  input logic               clk,
  input logic               reset,
  button_debounce_if.slave  pins
);

  logic [NUM_BUTTONS:0]   raw_all;
  logic [NUM_BUTTONS:0]   level_all;
  logic [NUM_BUTTONS-1:0] pulse_btn;
  // The switch has no pulse output; its channel pulse is sunk here.
  logic                   switch_pulse_unused;

  assign raw_all = {pins.switch_raw, pins.buttons_raw};

  // Channels 0..NUM_BUTTONS-1 are buttons, channel NUM_BUTTONS is the switch.
  for (genvar i = 0; i <= NUM_BUTTONS; i++) begin : g_chan
    if (i < NUM_BUTTONS) begin : g_btn
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (raw_all[i]),
        .level_o(level_all[i]),
        .pulse_o(pulse_btn[i])
      );
    end else begin : g_sw
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (raw_all[i]),
        .level_o(level_all[i]),
        .pulse_o(switch_pulse_unused)
      );
    end
  end

  assign pins.buttons       = level_all[NUM_BUTTONS-1:0];
  assign pins.switch        = level_all[NUM_BUTTONS];
  assign pins.buttons_pulse = pulse_btn;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4 and 5 buttons.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the
// edge under test, so "edge k" is the k-th rising edge after a raw change.
module tb_button_debounce;

  localparam int unsigned Dc = 4;
  localparam int unsigned Nb = 5;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  button_debounce_if #(.NUM_BUTTONS(Nb)) bus ();

  button_debounce #(
    .DEBOUNCE_CYCLES(Dc),
    .NUM_BUTTONS    (Nb)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pins (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [4:0] btn, input logic [4:0] pul,
                            input logic sw);
    check_eq({tag, ".buttons"}, {3'b0, bus.buttons}, {3'b0, btn});
    check_eq({tag, ".pulse"},   {3'b0, bus.buttons_pulse}, {3'b0, pul});
    check_eq({tag, ".switch"},  {7'b0, bus.switch}, {7'b0, sw});
  endtask

  initial begin
    reset          = 1'b1;
    bus.buttons_raw = '0;
    bus.switch_raw  = 1'b0;
    repeat (3) step();
    check_outs("reset", 5'b0, 5'b0, 1'b0);
    reset = 1'b0;
    repeat (4) step();

    // Single press: output at edge 6, one-cycle pulse.
    bus.buttons_raw = 5'b00001;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_outs("press_wait", 5'b0, 5'b0, 1'b0);
    end
    step();
    check_outs("press_edge6", 5'b00001, 5'b00001, 1'b0);
    step();
    check_outs("press_after", 5'b00001, 5'b0, 1'b0);

    // Release: clears at edge 6, never pulses.
    bus.buttons_raw = 5'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_outs("release_wait", 5'b00001, 5'b0, 1'b0);
    end
    step();
    check_outs("release_edge6", 5'b0, 5'b0, 1'b0);

    // Re-press gives a fresh single pulse.
    bus.buttons_raw = 5'b00001;
    repeat (5) step();
    check_outs("repress_edge5", 5'b0, 5'b0, 1'b0);
    step();
    check_outs("repress_edge6", 5'b00001, 5'b00001, 1'b0);
    step();
    check_outs("repress_after", 5'b00001, 5'b0, 1'b0);
    bus.buttons_raw = 5'b0;
    repeat (10) step();
    check_outs("repress_clear", 5'b0, 5'b0, 1'b0);

    // 3-cycle glitch is rejected.
    bus.buttons_raw = 5'b00010;
    repeat (3) step();
    bus.buttons_raw = 5'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_outs("glitch3", 5'b0, 5'b0, 1'b0);
    end

    // 4-cycle pulse is exactly long enough to be accepted.
    bus.buttons_raw = 5'b01000;
    repeat (4) step();
    bus.buttons_raw = 5'b0;
    step();
    check_outs("pulse4_edge5", 5'b0, 5'b0, 1'b0);
    step();
    check_outs("pulse4_edge6", 5'b01000, 5'b01000, 1'b0);
    repeat (4) step();
    check_outs("pulse4_edge10", 5'b0, 5'b0, 1'b0);
    repeat (4) step();

    // Bounce every cycle for 20 cycles, then settle on 00100.
    for (int k = 0; k < 20; k++) begin
      bus.buttons_raw = (k % 2 == 0) ? 5'b11111 : 5'b00000;
      step();
      check_outs("bounce", 5'b0, 5'b0, 1'b0);
    end
    bus.buttons_raw = 5'b00100;
    repeat (5) step();
    check_outs("settle_edge5", 5'b0, 5'b0, 1'b0);
    step();
    check_outs("settle_edge6", 5'b00100, 5'b00100, 1'b0);
    step();
    check_outs("settle_after", 5'b00100, 5'b0, 1'b0);
    bus.buttons_raw = 5'b0;
    repeat (10) step();

    // Simultaneous buttons and switch.
    bus.buttons_raw = 5'b10111;
    bus.switch_raw  = 1'b1;
    repeat (5) step();
    check_outs("multi_edge5", 5'b0, 5'b0, 1'b0);
    step();
    check_outs("multi_edge6", 5'b10111, 5'b10111, 1'b1);
    step();
    check_outs("multi_after", 5'b10111, 5'b0, 1'b1);
    bus.switch_raw = 1'b0;
    repeat (5) step();
    check_outs("sw_off_edge5", 5'b10111, 5'b0, 1'b1);
    step();
    check_outs("sw_off_edge6", 5'b10111, 5'b0, 1'b0);
    bus.buttons_raw = 5'b0;
    repeat (10) step();
    check_outs("multi_clear", 5'b0, 5'b0, 1'b0);

    // Reset at edge 4 of a held press restarts the full latency.
    bus.buttons_raw = 5'b00001;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_outs("rst_edge4", 5'b0, 5'b0, 1'b0);
    for (int k = 5; k <= 9; k++) begin
      step();
      check_outs("rst_wait", 5'b0, 5'b0, 1'b0);
    end
    step();
    check_outs("rst_edge10", 5'b00001, 5'b00001, 1'b0);
    step();
    check_outs("rst_after", 5'b00001, 5'b0, 1'b0);
    repeat (5) step();
    check_outs("rst_hold", 5'b00001, 5'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable-sample count required before a debounced level changes; legal range >= 2.
REQ-002 SHALL have parameter NUM_BUTTONS, default 5, number of push-button channels.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port buttons_raw  input  NUM_BUTTONS  asynchronous, bouncing push-button levels.
REQ-006 SHALL have port switch_raw  input  1  asynchronous, bouncing slide-switch level.
REQ-007 SHALL have port buttons  output  NUM_BUTTONS  debounced button levels, registered.
REQ-008 SHALL have port buttons_pulse  output  NUM_BUTTONS  one-cycle pulse per debounced 0->1 button transition, registered.
REQ-009 SHALL have port switch  output  1  debounced switch level, registered; feeds mux_control switch input directly.

Function
REQ-010 Each of the NUM_BUTTONS+1 inputs SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-011 Each channel SHALL hold a stable level and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 Synchronized level != stable level: counter SHALL increment by 1 per cycle.
REQ-013 Synchronized level == stable level: counter SHALL clear to 0 that cycle, discarding partial counts (glitch rejection).
REQ-014 Counter == DEBOUNCE_CYCLES-1 with mismatch still present: stable level SHALL take the synchronized value and the counter SHALL clear to 0 on the same edge.
REQ-015 Latency: a raw change held steady SHALL appear on the debounced output at exactly the (DEBOUNCE_CYCLES+2)th rising edge after the raw change.
REQ-016 A raw pulse or bounce shorter than DEBOUNCE_CYCLES cycles SHALL never change the debounced output.
REQ-017 buttons_pulse[i] SHALL be 1 for exactly the single cycle in which buttons[i] goes 0->1, and 0 otherwise; release (1->0) SHALL produce no pulse.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on any subset SHALL each obey REQ-012..REQ-017 with no priority or interaction.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and never wraps.
REQ-020 switch SHALL use identical debounce logic and SHALL have no pulse output.

Reset
REQ-021 With reset high at a rising edge: all synchronizer flops, stable levels, counters, buttons, buttons_pulse and switch SHALL be 0.
REQ-022 Reset asserted mid-count SHALL discard the count; after release, a still-held input SHALL take the full latency of REQ-015, measured from the first edge with reset low.
REQ-023 A button held high through reset release SHALL produce exactly one pulse once debounced.

Structure
REQ-024 NUM_BUTTONS default, DEBOUNCE_CYCLES default and the synthesis-board count (1_000_000 at 100 MHz) SHALL live in the shared project constants package/header.
REQ-025 A sub-module debounce_channel (synchronizer, counter, stable flop, rise-edge pulse) SHALL be instantiated NUM_BUTTONS+1 times via generate; it SHALL expose a pulse output, which is left unconnected for the switch instance.
REQ-026 No combinational path SHALL exist from any raw input to any output.

Verification (DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-027 buttons_raw=5'b00001 held from edge 0 -> buttons=5'b00001 from edge 6; buttons_pulse=5'b00001 for that cycle only.
REQ-028 buttons_raw[1] high for 3 cycles, then low -> buttons and buttons_pulse stay 0.
REQ-029 buttons_raw toggling 0/1 every cycle for 20 cycles, then 5'b00100 held -> buttons=5'b00100 exactly 6 edges after the last toggle, with one pulse.
REQ-030 buttons_raw=5'b10111 and switch_raw=1 on the same edge -> buttons=5'b10111 and switch=1 on the same edge 6; buttons_pulse=5'b10111 for one cycle; switch_raw=0 later -> switch=0 6 edges after, with no pulse.
REQ-031 reset pulsed at edge 4 of a held press -> no output change at edge 6; buttons set at edge 6 counted from reset release, with one pulse.
REQ-032 Button held then released -> buttons clears 6 edges after release, with no pulse; re-press -> new single pulse.
